// File: rtl/char_patch_ctrl.sv
// Character-ROM patch overlay: a small (addr, byte) table matched against every
// lookup, configured through a req/ack port with write, disable, read and clear-all.
//
// state   | meaning
// IDLE    | waiting for cfg_req; lookups active
// ACK     | one-cycle cfg_ack pulse after write/disable/read or a finished clear
// CLEAR   | invalidating entries one per cycle; busy high, lookups blocked
module char_patch_ctrl #(
    parameter int ENTRIES = 8,
    parameter int AW      = 11,
    parameter int DW      = 8,
    localparam int IW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             override,
    input  logic [AW-1:0]    a,
    output logic [DW-1:0]    q,
    output logic             patch,
    input  logic             cfg_req,
    input  logic [1:0]       cfg_op,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DW-1:0]    cfg_data,
    output logic             cfg_ack,
    output logic [AW+DW:0]   cfg_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_DISABLE = 2'b01;
    localparam logic [1:0] OP_CLEAR   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_clear_start;
    logic [IW-1:0]      r_cnt;

    logic               r_valid [ENTRIES];
    logic [AW-1:0]      r_addr  [ENTRIES];
    logic [DW-1:0]      r_data  [ENTRIES];

    logic               w_hit;
    logic [DW-1:0]      w_hit_data;
    logic [DW-1:0]      r_q;
    logic               r_patch;
    logic [AW+DW:0]     r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cfg_op == OP_CLEAR) ? S_CLEAR : S_ACK;
                end
            end
            S_CLEAR: begin
                if (r_cnt == IW'(ENTRIES - 1)) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_clear_start = w_accept && (cfg_op == OP_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clear_start) begin
            r_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_accept && cfg_op == OP_WRITE) begin
                r_valid[cfg_idx] <= 1'b1;
                r_addr[cfg_idx]  <= cfg_addr;
                r_data[cfg_idx]  <= cfg_data;
            end
            if (w_accept && cfg_op == OP_DISABLE) begin
                r_valid[cfg_idx] <= 1'b0;
            end
            if (r_state == S_CLEAR) begin
                r_valid[r_cnt] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_accept && cfg_op == OP_READ) begin
            r_rdata <= {r_valid[cfg_idx], r_addr[cfg_idx], r_data[cfg_idx]};
        end
    end

    // Scan from the top so the lowest matching index is the last assignment.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_addr[i] == a) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[i];
            end
        end
    end

    // A lookup coinciding with the clear-all accept is also blocked so that
    // patch stays low for every cycle busy is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_patch <= 1'b0;
        end else if (override && w_hit && r_state != S_CLEAR && !w_clear_start) begin
            r_q     <= w_hit_data;
            r_patch <= 1'b1;
        end else begin
            r_q     <= '0;
            r_patch <= 1'b0;
        end
    end

    assign q         = r_q;
    assign patch     = r_patch;
    assign cfg_rdata = r_rdata;
    assign cfg_ack   = (r_state == S_ACK);
    assign busy      = (r_state == S_CLEAR);

endmodule

// File: tb/tb_char_patch_ctrl.sv
// Bench for char_patch_ctrl: directed scenarios plus randomized lookups and
// configuration ops checked against an associative-table reference model.
module tb_char_patch_ctrl;
    localparam int ENTRIES = 8;
    localparam int AW      = 11;
    localparam int DW      = 8;
    localparam int IW      = 3;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             override = 1'b0;
    logic [AW-1:0]    a        = '0;
    logic [DW-1:0]    q;
    logic             patch;
    logic             cfg_req  = 1'b0;
    logic [1:0]       cfg_op   = 2'b00;
    logic [IW-1:0]    cfg_idx  = '0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [DW-1:0]    cfg_data = '0;
    logic             cfg_ack;
    logic [AW+DW:0]   cfg_rdata;
    logic             busy;

    int total = 0;
    int bad   = 0;

    bit            m_valid [ENTRIES];
    logic [AW-1:0] m_addr  [ENTRIES];
    logic [DW-1:0] m_data  [ENTRIES];

    char_patch_ctrl #(.ENTRIES(ENTRIES), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .override(override), .a(a), .q(q), .patch(patch),
        .cfg_req(cfg_req), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_apply(input logic [1:0] op, input int idx,
                                        input logic [AW-1:0] ad, input logic [DW-1:0] d);
        case (op)
            2'b00: begin m_valid[idx] = 1'b1; m_addr[idx] = ad; m_data[idx] = d; end
            2'b01: m_valid[idx] = 1'b0;
            2'b10: model_reset();
            default: ;
        endcase
    endfunction

    function automatic void model_lookup(input logic [AW-1:0] la, input logic ov,
                                         output logic [DW-1:0] eq, output logic ep);
        bit found;
        found = 1'b0;
        eq = '0;
        ep = 1'b0;
        if (ov) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (!found && m_valid[i] && m_addr[i] == la) begin
                    found = 1'b1;
                    eq = m_data[i];
                    ep = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one configuration request and reports ack latency (edges after the
    // accept edge, 0 on timeout), cycles with busy high, and cfg_ack one cycle later.
    task automatic do_cfg(input logic [1:0] op, input int idx, input logic [AW-1:0] ad,
                          input logic [DW-1:0] d, output int lat, output int bc,
                          output logic ack_after);
        cfg_req  = 1'b1;
        cfg_op   = op;
        cfg_idx  = IW'(idx);
        cfg_addr = ad;
        cfg_data = d;
        tick();
        model_apply(op, idx, ad, d);
        lat = 0;
        bc  = 0;
        for (int k = 1; k <= 4 * ENTRIES; k++) begin
            if (busy) bc++;
            if (cfg_ack) begin
                lat = k;
                break;
            end
            tick();
        end
        cfg_req = 1'b0;
        tick();
        ack_after = cfg_ack;
    endtask

    task automatic do_lookup(input logic [AW-1:0] la, input logic ov,
                             output logic [DW-1:0] eq, output logic ep);
        model_lookup(la, ov, eq, ep);
        a = la;
        override = ov;
        tick();
    endtask

    task automatic test_reset();
        int lat, bc;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        #2;
        total += 5;
        if (q !== '0)         begin bad++; $display("FAIL rst0_q got=%h exp=0", q); end
        if (patch !== 1'b0)   begin bad++; $display("FAIL rst0_patch got=%b exp=0", patch); end
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL rst0_ack got=%b exp=0", cfg_ack); end
        if (busy !== 1'b0)    begin bad++; $display("FAIL rst0_busy got=%b exp=0", busy); end
        if (cfg_rdata !== '0) begin bad++; $display("FAIL rst0_rdata got=%h exp=0", cfg_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_reset();
        do_cfg(2'b00, 2, 11'h180, 8'h03, lat, bc, aa);
        do_cfg(2'b11, 2, '0, '0, lat, bc, aa);
        do_lookup(11'h180, 1'b1, eq, ep);
        total++;
        if (patch !== 1'b1) begin bad++; $display("FAIL rst_pre_patch got=%b exp=1", patch); end
        rst_n = 1'b0;
        #1;
        model_reset();
        total += 5;
        if (q !== '0)         begin bad++; $display("FAIL rst_q got=%h exp=0", q); end
        if (patch !== 1'b0)   begin bad++; $display("FAIL rst_patch got=%b exp=0", patch); end
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", cfg_ack); end
        if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (cfg_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", cfg_rdata); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        do_lookup(11'h180, 1'b1, eq, ep);
        total++;
        if (patch !== 1'b0) begin bad++; $display("FAIL rst_after_patch got=%b exp=0", patch); end
    endtask

    task automatic test_write_lookup();
        int lat, bc;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        override = 1'b0;
        do_cfg(2'b00, 2, 11'h180, 8'h03, lat, bc, aa);
        total += 2;
        if (lat !== 1)   begin bad++; $display("FAIL wr_ack_lat got=%0d exp=1", lat); end
        if (aa !== 1'b0) begin bad++; $display("FAIL wr_ack_width got=%b exp=0", aa); end
        do_lookup(11'h180, 1'b1, eq, ep);
        total += 2;
        if (q !== 8'h03)    begin bad++; $display("FAIL wl_hit_q got=%h exp=03", q); end
        if (patch !== 1'b1) begin bad++; $display("FAIL wl_hit_patch got=%b exp=1", patch); end
        do_lookup(11'h181, 1'b1, eq, ep);
        total += 2;
        if (q !== '0)       begin bad++; $display("FAIL wl_miss_q got=%h exp=0", q); end
        if (patch !== 1'b0) begin bad++; $display("FAIL wl_miss_patch got=%b exp=0", patch); end
        do_lookup(11'h180, 1'b0, eq, ep);
        total += 2;
        if (q !== '0)       begin bad++; $display("FAIL wl_ovr0_q got=%h exp=0", q); end
        if (patch !== 1'b0) begin bad++; $display("FAIL wl_ovr0_patch got=%b exp=0", patch); end
    endtask

    task automatic test_priority_collision();
        int lat, bc;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        override = 1'b0;
        do_cfg(2'b00, 5, 11'h1a7, 8'hf8, lat, bc, aa);
        do_cfg(2'b00, 1, 11'h1a7, 8'hff, lat, bc, aa);
        do_lookup(11'h1a7, 1'b1, eq, ep);
        total++;
        if (q !== 8'hff) begin bad++; $display("FAIL prio_q got=%h exp=ff", q); end
        cfg_req  = 1'b1;
        cfg_op   = 2'b00;
        cfg_idx  = 3'd1;
        cfg_addr = 11'h1a7;
        cfg_data = 8'h11;
        a        = 11'h1a7;
        override = 1'b1;
        tick();
        model_apply(2'b00, 1, 11'h1a7, 8'h11);
        total += 3;
        if (q !== 8'hff)      begin bad++; $display("FAIL coll_same_q got=%h exp=ff", q); end
        if (patch !== 1'b1)   begin bad++; $display("FAIL coll_same_patch got=%b exp=1", patch); end
        if (cfg_ack !== 1'b1) begin bad++; $display("FAIL coll_ack got=%b exp=1", cfg_ack); end
        cfg_req = 1'b0;
        tick();
        total++;
        if (q !== 8'h11) begin bad++; $display("FAIL coll_next_q got=%h exp=11", q); end
    endtask

    task automatic test_disable_readback();
        int lat, bc;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        override = 1'b0;
        do_cfg(2'b01, 1, '0, '0, lat, bc, aa);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL dis_ack_lat got=%0d exp=1", lat); end
        do_lookup(11'h1a7, 1'b1, eq, ep);
        total++;
        if (q !== 8'hf8) begin bad++; $display("FAIL dis_q got=%h exp=f8", q); end
        override = 1'b0;
        do_cfg(2'b11, 5, '0, '0, lat, bc, aa);
        total += 2;
        if (lat !== 1) begin bad++; $display("FAIL rd_ack_lat got=%0d exp=1", lat); end
        if (cfg_rdata !== {1'b1, 11'h1a7, 8'hf8})
            begin bad++; $display("FAIL rd5_rdata got=%h exp=%h", cfg_rdata, {1'b1, 11'h1a7, 8'hf8}); end
        do_cfg(2'b11, 1, '0, '0, lat, bc, aa);
        total++;
        if (cfg_rdata[AW+DW] !== 1'b0) begin bad++; $display("FAIL rd1_valid got=%b exp=0", cfg_rdata[AW+DW]); end
    endtask

    task automatic test_clear_all();
        int lat, bc, pbad;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        override = 1'b0;
        for (int i = 0; i < ENTRIES; i++)
            do_cfg(2'b00, i, AW'(11'h100 + i), DW'(8'h40 + i), lat, bc, aa);
        override = 1'b1;
        a        = 11'h100;
        cfg_req  = 1'b1;
        cfg_op   = 2'b10;
        tick();
        model_apply(2'b10, 0, '0, '0);
        lat = 0;
        bc = 0;
        pbad = 0;
        for (int k = 1; k <= 4 * ENTRIES; k++) begin
            if (busy) begin
                bc++;
                if (patch !== 1'b0) pbad++;
            end
            if (cfg_ack) begin
                lat = k;
                break;
            end
            a = AW'(11'h100 + (k % ENTRIES));
            tick();
        end
        total += 4;
        if (bc !== ENTRIES)     begin bad++; $display("FAIL clr_busy_cycles got=%0d exp=%0d", bc, ENTRIES); end
        if (lat !== ENTRIES + 1) begin bad++; $display("FAIL clr_ack_lat got=%0d exp=%0d", lat, ENTRIES + 1); end
        if (pbad !== 0)         begin bad++; $display("FAIL clr_patch_busy got=%0d exp=0", pbad); end
        if (patch !== 1'b0)     begin bad++; $display("FAIL clr_patch_ack got=%b exp=0", patch); end
        cfg_req = 1'b0;
        tick();
        total++;
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL clr_ack_once got=%b exp=0", cfg_ack); end
        for (int i = 0; i < ENTRIES; i++) begin
            do_lookup(AW'(11'h100 + i), 1'b1, eq, ep);
            total++;
            if (patch !== ep) begin bad++; $display("FAIL clr_after_patch%0d got=%b exp=%b", i, patch, ep); end
        end
        override = 1'b0;
        cfg_req  = 1'b1;
        cfg_op   = 2'b00;
        cfg_idx  = 3'd3;
        cfg_addr = 11'h2c5;
        cfg_data = 8'h5a;
        tick();
        model_apply(2'b00, 3, 11'h2c5, 8'h5a);
        total++;
        if (cfg_ack !== 1'b1) begin bad++; $display("FAIL hold_ack1 got=%b exp=1", cfg_ack); end
        cfg_op = 2'b11;
        tick();
        total++;
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL hold_idle got=%b exp=0", cfg_ack); end
        tick();
        total += 2;
        if (cfg_ack !== 1'b1) begin bad++; $display("FAIL hold_ack2 got=%b exp=1", cfg_ack); end
        if (cfg_rdata !== {1'b1, 11'h2c5, 8'h5a})
            begin bad++; $display("FAIL hold_rdata got=%h exp=%h", cfg_rdata, {1'b1, 11'h2c5, 8'h5a}); end
        cfg_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_during_clear();
        int lat, bc, acks;
        logic aa;
        logic [DW-1:0] eq;
        logic ep;
        override = 1'b0;
        for (int i = 0; i < 4; i++)
            do_cfg(2'b00, i, AW'(11'h300 + i), DW'(8'h90 + i), lat, bc, aa);
        cfg_req = 1'b1;
        cfg_op  = 2'b10;
        tick();
        cfg_req = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rdc_busy_pre got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        total += 2;
        if (busy !== 1'b0)    begin bad++; $display("FAIL rdc_busy got=%b exp=0", busy); end
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL rdc_ack got=%b exp=0", cfg_ack); end
        acks = 0;
        repeat (2) begin tick(); if (cfg_ack) acks++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ENTRIES + 4) begin tick(); if (cfg_ack || busy) acks++; end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL rdc_no_ack got=%0d exp=0", acks); end
        for (int i = 0; i < 4; i++) begin
            do_lookup(AW'(11'h300 + i), 1'b1, eq, ep);
            total++;
            if (patch !== ep) begin bad++; $display("FAIL rdc_patch%0d got=%b exp=%b", i, patch, ep); end
        end
        override = 1'b0;
        do_cfg(2'b11, 2, '0, '0, lat, bc, aa);
        total += 2;
        if (lat !== 1) begin bad++; $display("FAIL rdc_idle_lat got=%0d exp=1", lat); end
        if (cfg_rdata[AW+DW] !== 1'b0) begin bad++; $display("FAIL rdc_rd_valid got=%b exp=0", cfg_rdata[AW+DW]); end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [4];
        int lat, bc, sel, idx;
        logic aa;
        logic [1:0] op;
        logic [AW-1:0] la;
        logic [DW-1:0] eq;
        logic ep;
        pool[0] = 11'h1a7; pool[1] = 11'h180; pool[2] = 11'h7ff; pool[3] = 11'h000;
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 19);
            if (sel < 12) begin
                la = ($urandom_range(0, 4) == 0) ? AW'($urandom) : pool[$urandom_range(0, 3)];
                do_lookup(la, ($urandom_range(0, 3) != 0), eq, ep);
                total += 2;
                if (q !== eq)     begin bad++; $display("FAIL rnd%0d_q got=%h exp=%h", it, q, eq); end
                if (patch !== ep) begin bad++; $display("FAIL rnd%0d_patch got=%b exp=%b", it, patch, ep); end
            end else begin
                override = 1'b0;
                idx = $urandom_range(0, ENTRIES - 1);
                if (sel == 19 && $urandom_range(0, 2) == 0) op = 2'b10;
                else if (sel < 16) op = 2'b00;
                else if (sel < 18) op = 2'b11;
                else op = 2'b01;
                if (op == 2'b11) begin
                    eq = m_valid[idx] ? m_data[idx] : '0;
                end
                do_cfg(op, idx, pool[$urandom_range(0, 3)], DW'($urandom), lat, bc, aa);
                total++;
                if (op == 2'b10) begin
                    if (lat !== ENTRIES + 1) begin bad++; $display("FAIL rnd%0d_clr_lat got=%0d exp=%0d", it, lat, ENTRIES + 1); end
                end else begin
                    if (lat !== 1) begin bad++; $display("FAIL rnd%0d_lat got=%0d exp=1", it, lat); end
                end
                if (op == 2'b11) begin
                    total++;
                    if (m_valid[idx]) begin
                        if (cfg_rdata !== {1'b1, m_addr[idx], m_data[idx]})
                            begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", it, cfg_rdata, {1'b1, m_addr[idx], m_data[idx]}); end
                    end else begin
                        if (cfg_rdata[AW+DW] !== 1'b0)
                            begin bad++; $display("FAIL rnd%0d_rvalid got=%b exp=0", it, cfg_rdata[AW+DW]); end
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_lookup();
        test_priority_collision();
        test_disable_readback();
        test_clear_all();
        test_reset_during_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/char_patch_ctrl.md
# char_patch_ctrl

Programmable controller for the character-ROM patch overlay. It holds a small table of (address, byte) patch entries, configured over a request/acknowledge port by the CPU-side loader. On every video character-ROM lookup it matches the address against the table and returns the patched byte plus a `patch` flag; the downstream mux then selects between the patch byte and the stock ROM. It replaces hard-wired patch contents with a table that can be written, disabled, read back and bulk-cleared at run time.

## Interface
Parameters:
- `ENTRIES`, 8: number of patch entries; power of two, 2..16.
- `AW`, 11: character-ROM address width.
- `DW`, 8: character-ROM data width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `override`  in  1  lookup enable; patching is active only while high.
- `a`  in  AW  character-ROM lookup address.
- `q`  out  DW  patched byte (registered).
- `patch`  out  1  high when `q` is valid and must replace the ROM byte (registered).
- `cfg_req`  in  1  configuration request; level, held until `cfg_ack`.
- `cfg_op`  in  2  operation: 00 write entry, 01 disable entry, 10 clear all, 11 read entry.
- `cfg_idx`  in  log2(ENTRIES)  entry index for ops 00, 01 and 11.
- `cfg_addr`  in  AW  patch address for op 00.
- `cfg_data`  in  DW  patch byte for op 00.
- `cfg_ack`  out  1  one-cycle completion pulse.
- `cfg_rdata`  out  1+AW+DW  read-back data {valid, addr, data}; loaded only by op 11.
- `busy`  out  1  high while a clear-all is in progress.

## Operation
- Table: per entry, a `valid` bit, an AW-bit address and a DW-bit byte. Reset clears every `valid` bit. Address and data fields are don't-care while `valid` is 0.
- Lookup, every cycle. A hit requires `override`=1, `busy`=0, and at least one valid entry with addr==`a`. On a hit, the registered outputs become `q`=byte of the lowest-index matching entry and `patch`=1. Otherwise `q`=0 and `patch`=0. `q` is never tri-stated.
- Configuration FSM states: IDLE, ACK, CLEAR.
  - IDLE, `cfg_req`=1 → the request is accepted at this edge.
    - op 00: write addr, byte and valid=1 into entry `cfg_idx`.
    - op 01: clear the valid bit of entry `cfg_idx`.
    - op 11: load `cfg_rdata` from entry `cfg_idx`; the table is unchanged.
    - For ops 00, 01 and 11, go to ACK.
    - op 10: set `busy`=1, reset the counter to 0, go to CLEAR.
  - CLEAR: each edge clears valid[cnt] and increments cnt. On the edge that clears entry ENTRIES-1, set `busy`=0 and go to ACK.
  - ACK: `cfg_ack`=1 for this one cycle, then return to IDLE. The requester must drop `cfg_req` in the ACK cycle. A `cfg_req` still high in the first IDLE cycle after ACK is treated as a new request.
- `cfg_op`, `cfg_idx`, `cfg_addr` and `cfg_data` are sampled only at the accept edge.
- `cfg_req` is ignored in ACK and CLEAR.
- Reset values: `q`=0, `patch`=0, `cfg_ack`=0, `cfg_rdata`=0, `busy`=0, FSM in IDLE, counter 0, all entries invalid.
- Reset during CLEAR aborts the clear and enters IDLE with every entry invalid; no `cfg_ack` is generated for the aborted request.

## Timing
- Lookup latency is 1 cycle: `a`/`override` sampled at edge N drive `q`/`patch` after edge N. Full throughput, one lookup per cycle.
- Table writes take effect at the accept edge. A lookup sampled at that same edge sees the old contents; a lookup presented in the following cycle sees the new contents.
- Write, disable and read: `cfg_ack` is high in the cycle after the accept edge. The request-to-ack turnaround is 2 cycles including the request cycle.
- `cfg_rdata` is valid from the cycle `cfg_ack` is high and holds until the next op-11 accept.
- Clear-all: accept at edge E0; entries 0..ENTRIES-1 are cleared at edges E1..E_ENTRIES. `busy` is high from after E0 through edge E_ENTRIES. `cfg_ack` is high in the cycle after E_ENTRIES. Lookups return `patch`=0 for the whole time `busy` is high.
- There is no combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n`=0 mid-stream → `q`=0, `patch`=0, `cfg_ack`=0, `busy`=0, `cfg_rdata`=0. After release, `override`=1 with `a`=11'h0180 → `patch`=0.
- Write and lookup: write idx 2 with addr 11'h0180, data 8'h03. `cfg_ack` must pulse exactly 1 cycle after accept. Then `override`=1, `a`=11'h0180 → next cycle `q`=8'h03, `patch`=1. With `a`=11'h0181 → `q`=0, `patch`=0. With `override`=0 → `patch`=0.
- Priority and write/lookup collision: write idx 5 = (11'h01a7, 8'hf8), then idx 1 = (11'h01a7, 8'hff). Lookup 11'h01a7 → `q`=8'hff (lowest index wins). Present a lookup of 11'h01a7 at the same edge as a rewrite of idx 1 to 8'h11 → that lookup returns 8'hff, the next lookup returns 8'h11.
- Disable and read-back: disable idx 1, then lookup 11'h01a7 → `q`=8'hf8 from idx 5. Read idx 5 → `cfg_rdata`={1, 11'h01a7, 8'hf8}. Read idx 1 → valid bit 0.
- Clear-all: populate all 8 entries, issue op 10. `busy` must be high for exactly 8 cycles, `cfg_ack` must pulse once after them, and lookups must return `patch`=0 throughout and afterwards. Hold `cfg_req` high into the first IDLE cycle after ACK → a second request is accepted.
- Reset during clear: assert `rst_n`=0 three cycles into a clear → `busy`=0 immediately, no `cfg_ack`, FSM in IDLE, all entries invalid.
